// File: rtl/lsu_mmio.sv
// lsu_mmio: load-store unit for the single-cycle RV32I core.
// Holds the word-organised data memory and the memory-mapped I/O registers
// (LEDR, LEDG, HEX0-7, LCD) plus a 2-flop synchroniser for the switches.
// Stores commit on the rising edge of i_clk; loads are purely combinational.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_lsu_addr          byte address from the ALU
//   i_st_data           store data (rs2)
//   i_lsu_wren          store strobe
//   i_st_size           store size: 00 byte, 01 half, 10 word
//   i_sl_sel            load select: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
//   i_io_sw             raw asynchronous switch inputs
//   o_ld_data           extended load data (combinational)
//   o_misaligned        current access is misaligned (combinational)
//   o_io_ledr/ledg/lcd  peripheral registers
//   o_io_hex0..7        7-segment digit registers (active-low segments)
module lsu_mmio #(
  parameter int    DMEM_AW  = 11,
  parameter string MEM_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [1:0]  i_st_size,
  input  logic [2:0]  i_sl_sel,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_NONE = 2'd3;

  logic [31:0] dmem [2**(DMEM_AW-2)];

  logic [31:0]      ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [7:0][6:0]  hex_q, hex_d;
  logic [31:0]      sw_meta_q, sw_sync_q;

  logic [19:0]         page;
  logic [DMEM_AW-3:0]  widx;
  logic                sel_dmem, sel_ledr, sel_ledg, sel_hlo, sel_hhi, sel_lcd, sel_sw;
  logic [1:0]          acc_sz;
  logic [3:0]          be;
  logic [31:0]         wdata, rword, hlo_word, hhi_word, hlo_new, hhi_new;
  logic [7:0]          ld_b;
  logic [15:0]         ld_h;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] en);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = en[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return r;
  endfunction

  assign page     = i_lsu_addr[31:12];
  assign widx     = i_lsu_addr[DMEM_AW-1:2];
  assign sel_dmem = (i_lsu_addr[31:DMEM_AW] == '0);
  assign sel_ledr = (page == 20'h10000);
  assign sel_ledg = (page == 20'h10001);
  assign sel_hlo  = (page == 20'h10002);
  assign sel_hhi  = (page == 20'h10003);
  assign sel_lcd  = (page == 20'h10004);
  assign sel_sw   = (page == 20'h10010);

  // Bit 7 of each digit byte is not stored and reads back as 0.
  assign hlo_word = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
  assign hhi_word = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};

  // Access size follows the store size on a store and the load select otherwise.
  always_comb begin
    acc_sz = SZ_NONE;
    if (i_lsu_wren) begin
      acc_sz = (i_st_size == 2'b11) ? SZ_NONE : i_st_size;
    end else begin
      case (i_sl_sel)
        3'b000, 3'b011: acc_sz = SZ_B;
        3'b001, 3'b100: acc_sz = SZ_H;
        3'b010:         acc_sz = SZ_W;
        default:        acc_sz = SZ_NONE;
      endcase
    end
  end

  assign o_misaligned = ((acc_sz == SZ_H) && i_lsu_addr[0]) ||
                        ((acc_sz == SZ_W) && (i_lsu_addr[1:0] != 2'b00));

  always_comb begin
    be    = 4'b0000;
    wdata = i_st_data;
    case (acc_sz)
      SZ_B: begin
        be    = 4'b0001 << i_lsu_addr[1:0];
        wdata = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_st_data[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!i_lsu_wren || o_misaligned) be = 4'b0000;
  end

  always_comb begin
    ledr_d  = merge(ledr_q, wdata, sel_ledr ? be : 4'b0000);
    ledg_d  = merge(ledg_q, wdata, sel_ledg ? be : 4'b0000);
    lcd_d   = merge(lcd_q,  wdata, sel_lcd  ? be : 4'b0000);
    hlo_new = merge(hlo_word, wdata, sel_hlo ? be : 4'b0000);
    hhi_new = merge(hhi_word, wdata, sel_hhi ? be : 4'b0000);
    hex_d   = hex_q;
    for (int k = 0; k < 4; k++) begin
      hex_d[k]   = hlo_new[8*k +: 7];
      hex_d[k+4] = hhi_new[8*k +: 7];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q    <= '0;
      ledg_q    <= '0;
      lcd_q     <= '0;
      hex_q     <= {8{7'h7F}};
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      lcd_q     <= lcd_d;
      hex_q     <= hex_d;
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // DMEM has no reset; gating with i_rst_n drops a store caught by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && sel_dmem) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) dmem[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rword = '0;
    if      (sel_dmem) rword = dmem[widx];
    else if (sel_ledr) rword = ledr_q;
    else if (sel_ledg) rword = ledg_q;
    else if (sel_hlo)  rword = hlo_word;
    else if (sel_hhi)  rword = hhi_word;
    else if (sel_lcd)  rword = lcd_q;
    else if (sel_sw)   rword = sw_sync_q;
  end

  always_comb begin
    case (i_lsu_addr[1:0])
      2'd0:    ld_b = rword[7:0];
      2'd1:    ld_b = rword[15:8];
      2'd2:    ld_b = rword[23:16];
      default: ld_b = rword[31:24];
    endcase
    ld_h = i_lsu_addr[1] ? rword[31:16] : rword[15:0];
    case (i_sl_sel)
      3'b000:  o_ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  o_ld_data = {{16{ld_h[15]}}, ld_h};
      3'b010:  o_ld_data = rword;
      3'b011:  o_ld_data = {24'h0, ld_b};
      3'b100:  o_ld_data = {16'h0, ld_h};
      default: o_ld_data = '0;
    endcase
    if (o_misaligned) o_ld_data = '0;
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_lsu_mmio.sv
module tb_lsu_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, st_data, io_sw;
  logic        wren;
  logic [1:0]  st_size;
  logic [2:0]  sl_sel;
  logic [31:0] ld_data, ledr, ledg, lcd;
  logic        misaligned;
  logic [6:0]  hex [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mmio dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_addr(addr), .i_st_data(st_data),
    .i_lsu_wren(wren), .i_st_size(st_size), .i_sl_sel(sl_sel), .i_io_sw(io_sw),
    .o_ld_data(ld_data), .o_misaligned(misaligned), .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex0(hex[0]), .o_io_hex1(hex[1]), .o_io_hex2(hex[2]), .o_io_hex3(hex[3]),
    .o_io_hex4(hex[4]), .o_io_hex5(hex[5]), .o_io_hex6(hex[6]), .o_io_hex7(hex[7]),
    .o_io_lcd(lcd)
  );

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    addr = a; st_data = d; st_size = sz; wren = 1'b1;
    @(posedge clk);
    #1 wren = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] sel);
    @(negedge clk);
    addr = a; sl_sel = sel; wren = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    st(32'h1000_0000, 32'hDEAD_0001, 2'b10);
    st(32'h1000_1000, 32'hDEAD_0002, 2'b10);
    st(32'h1000_4000, 32'hDEAD_0003, 2'b10);
    st(32'h1000_2000, 32'h0102_0304, 2'b10);
    st(32'h1000_3000, 32'h0506_0708, 2'b10);
    // Store in flight when reset hits mid-cycle.
    @(negedge clk);
    addr = 32'h1000_0000; st_data = 32'h0000_1234; st_size = 2'b10; wren = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ledr !== 32'h0) begin failures++; $display("FAIL reset_ledr got=%h exp=%h", ledr, 32'h0); end
    checks++; if (ledg !== 32'h0) begin failures++; $display("FAIL reset_ledg got=%h exp=%h", ledg, 32'h0); end
    checks++; if (lcd !== 32'h0) begin failures++; $display("FAIL reset_lcd got=%h exp=%h", lcd, 32'h0); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex[k] !== 7'h7F) begin failures++; $display("FAIL reset_hex%0d got=%h exp=%h", k, hex[k], 7'h7F); end
    end
    @(posedge clk); #1;
    checks++; if (ledr !== 32'h0) begin failures++; $display("FAIL reset_store_lost got=%h exp=%h", ledr, 32'h0); end
    @(negedge clk);
    addr = 32'h1000_1000; st_data = 32'h0000_0077; st_size = 2'b10; wren = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1 wren = 1'b0;
    checks++; if (ledg !== 32'h77) begin failures++; $display("FAIL reset_first_store got=%h exp=%h", ledg, 32'h77); end
  endtask

  task automatic test_byte_loads;
    st(32'h10, 32'h1122_3344, 2'b10);
    st(32'h12, 32'h0000_0080, 2'b00);
    ld(32'h10, 3'b010);
    checks++; if (ld_data !== 32'h1180_3344) begin failures++; $display("FAIL lw_10 got=%h exp=%h", ld_data, 32'h1180_3344); end
    ld(32'h12, 3'b000);
    checks++; if (ld_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_12 got=%h exp=%h", ld_data, 32'hFFFF_FF80); end
    ld(32'h12, 3'b011);
    checks++; if (ld_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_12 got=%h exp=%h", ld_data, 32'h80); end
    ld(32'h12, 3'b001);
    checks++; if (ld_data !== 32'h0000_1180) begin failures++; $display("FAIL lh_12 got=%h exp=%h", ld_data, 32'h1180); end
    ld(32'h12, 3'b100);
    checks++; if (ld_data !== 32'h0000_1180) begin failures++; $display("FAIL lhu_12 got=%h exp=%h", ld_data, 32'h1180); end
    ld(32'h13, 3'b000);
    checks++; if (ld_data !== 32'h0000_0011) begin failures++; $display("FAIL lb_13 got=%h exp=%h", ld_data, 32'h11); end
    ld(32'h10, 3'b001);
    checks++; if (ld_data !== 32'h0000_3344) begin failures++; $display("FAIL lh_10 got=%h exp=%h", ld_data, 32'h3344); end
    st(32'h14, 32'h0000_0000, 2'b10);
    st(32'h16, 32'h5555_8001, 2'b01);
    ld(32'h16, 3'b001);
    checks++; if (ld_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_16 got=%h exp=%h", ld_data, 32'hFFFF_8001); end
    ld(32'h16, 3'b100);
    checks++; if (ld_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_16 got=%h exp=%h", ld_data, 32'h8001); end
    ld(32'h14, 3'b010);
    checks++; if (ld_data !== 32'h8001_0000) begin failures++; $display("FAIL sh_lanes got=%h exp=%h", ld_data, 32'h8001_0000); end
    ld(32'h10, 3'b101);
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL sel_101 got=%h exp=%h", ld_data, 32'h0); end
  endtask

  task automatic test_misaligned;
    st(32'h20, 32'h55AA_55AA, 2'b10);
    @(negedge clk);
    addr = 32'h21; st_data = 32'hDEAD_BEEF; st_size = 2'b10; wren = 1'b1;
    #1;
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_sw_flag got=%b exp=1", misaligned); end
    @(posedge clk); #1 wren = 1'b0;
    ld(32'h20, 3'b010);
    checks++; if (ld_data !== 32'h55AA_55AA) begin failures++; $display("FAIL mis_sw_nowrite got=%h exp=%h", ld_data, 32'h55AA_55AA); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_aligned_flag got=%b exp=0", misaligned); end
    ld(32'h13, 3'b001);
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL mis_lh_data got=%h exp=%h", ld_data, 32'h0); end
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_lh_flag got=%b exp=1", misaligned); end
    // Load size must come from sl_sel, not the stale word st_size.
    st_size = 2'b10;
    ld(32'h21, 3'b000);
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_lb_flag got=%b exp=0", misaligned); end
    checks++; if (ld_data !== 32'h0000_0055) begin failures++; $display("FAIL mis_lb_data got=%h exp=%h", ld_data, 32'h55); end
  endtask

  task automatic test_hex_leds;
    st(32'h1000_2000, 32'h7F40_0079, 2'b10);
    checks++; if (hex[3] !== 7'h7F) begin failures++; $display("FAIL hex3 got=%h exp=%h", hex[3], 7'h7F); end
    checks++; if (hex[2] !== 7'h40) begin failures++; $display("FAIL hex2 got=%h exp=%h", hex[2], 7'h40); end
    checks++; if (hex[1] !== 7'h00) begin failures++; $display("FAIL hex1 got=%h exp=%h", hex[1], 7'h00); end
    checks++; if (hex[0] !== 7'h79) begin failures++; $display("FAIL hex0 got=%h exp=%h", hex[0], 7'h79); end
    ld(32'h1000_2000, 3'b010);
    checks++; if (ld_data !== 32'h7F40_0079) begin failures++; $display("FAIL hex_lo_read got=%h exp=%h", ld_data, 32'h7F40_0079); end
    st(32'h1000_3005, 32'h0000_0080, 2'b00);
    checks++; if (hex[5] !== 7'h00) begin failures++; $display("FAIL hex5_alias got=%h exp=%h", hex[5], 7'h00); end
    checks++; if (hex[4] !== 7'h7F) begin failures++; $display("FAIL hex4_keep got=%h exp=%h", hex[4], 7'h7F); end
    st(32'h1000_0002, 32'h0000_ABCD, 2'b01);
    checks++; if (ledr !== 32'hABCD_0000) begin failures++; $display("FAIL ledr_sh got=%h exp=%h", ledr, 32'hABCD_0000); end
    st(32'h1000_1000, 32'h1234_5678, 2'b10);
    st(32'h1000_1FFD, 32'h0000_00AA, 2'b00);
    checks++; if (ledg !== 32'h1234_AA78) begin failures++; $display("FAIL ledg_sb_alias got=%h exp=%h", ledg, 32'h1234_AA78); end
    st(32'h1000_4000, 32'hCAFE_F00D, 2'b10);
    ld(32'h1000_4008, 3'b010);
    checks++; if (ld_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL lcd_read got=%h exp=%h", ld_data, 32'hCAFE_F00D); end
  endtask

  task automatic test_switch;
    ld(32'h1001_0000, 3'b010);
    io_sw = 32'h0000_0005;
    @(posedge clk); #1;
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL sw_one_edge got=%h exp=%h", ld_data, 32'h0); end
    @(posedge clk); #1;
    checks++; if (ld_data !== 32'h5) begin failures++; $display("FAIL sw_two_edges got=%h exp=%h", ld_data, 32'h5); end
    st(32'h1001_0000, 32'hFFFF_FFFF, 2'b10);
    ld(32'h1001_0000, 3'b010);
    checks++; if (ld_data !== 32'h5) begin failures++; $display("FAIL sw_store_ignored got=%h exp=%h", ld_data, 32'h5); end
  endtask

  task automatic test_unmapped;
    st(32'h2000_0000, 32'hFFFF_FFFF, 2'b10);
    checks++; if (ledr !== 32'hABCD_0000) begin failures++; $display("FAIL unm_ledr got=%h exp=%h", ledr, 32'hABCD_0000); end
    checks++; if (ledg !== 32'h1234_AA78) begin failures++; $display("FAIL unm_ledg got=%h exp=%h", ledg, 32'h1234_AA78); end
    checks++; if (lcd !== 32'hCAFE_F00D) begin failures++; $display("FAIL unm_lcd got=%h exp=%h", lcd, 32'hCAFE_F00D); end
    checks++; if (hex[0] !== 7'h79) begin failures++; $display("FAIL unm_hex0 got=%h exp=%h", hex[0], 7'h79); end
    ld(32'h0, 3'b010);
    ld(32'h10, 3'b010);
    checks++; if (ld_data !== 32'h1180_3344) begin failures++; $display("FAIL unm_dmem got=%h exp=%h", ld_data, 32'h1180_3344); end
    ld(32'h2000_0000, 3'b010);
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL unm_read got=%h exp=%h", ld_data, 32'h0); end
  endtask

  task automatic test_dmem_bound;
    st(32'h0, 32'h0102_0304, 2'b10);
    st(32'h800, 32'hFFFF_FFFF, 2'b10);
    ld(32'h0, 3'b010);
    checks++; if (ld_data !== 32'h0102_0304) begin failures++; $display("FAIL bound_noalias got=%h exp=%h", ld_data, 32'h0102_0304); end
    ld(32'h800, 3'b010);
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL bound_read got=%h exp=%h", ld_data, 32'h0); end
    st(32'h7FC, 32'hA5A5_0F0F, 2'b10);
    ld(32'h7FC, 3'b010);
    checks++; if (ld_data !== 32'hA5A5_0F0F) begin failures++; $display("FAIL bound_top got=%h exp=%h", ld_data, 32'hA5A5_0F0F); end
  endtask

  task automatic test_back_to_back;
    st(32'h30, 32'h0BAD_F00D, 2'b10);
    st(32'h34, 32'h1357_9BDF, 2'b10);
    st(32'h31, 32'h0000_00EE, 2'b00);
    ld(32'h30, 3'b010);
    checks++; if (ld_data !== 32'h0BAD_EE0D) begin failures++; $display("FAIL b2b_w0 got=%h exp=%h", ld_data, 32'h0BAD_EE0D); end
    ld(32'h34, 3'b010);
    checks++; if (ld_data !== 32'h1357_9BDF) begin failures++; $display("FAIL b2b_w1 got=%h exp=%h", ld_data, 32'h1357_9BDF); end
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; st_data = '0; wren = 1'b0;
    st_size = 2'b10; sl_sel = 3'b010; io_sw = '0;
    #22 rst_n = 1'b1;
    test_reset();
    test_byte_loads();
    test_misaligned();
    test_hex_leds();
    test_switch();
    test_unmapped();
    test_dmem_bound();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
